irom_fetch_stepper: RTL and testbench
=====================================

// Module: irom_fetch_stepper
// PURPOSE
//  Parametrised instruction-fetch sequencer for board-level IROM/decoder bring-up.
//  Owns the PC and drives a synchronous IROM. Advances in free-run (divided tick), single-step (button) or run-to-breakpoint mode.
//  Presents the fetched word with a valid strobe to display/decoder logic.
//  Replaces the fixed 1 s divider + PC+4 loop in per-lab test tops.
// PARAMETERS
//  XLEN      32          instruction/PC width
//  AW        6           IROM word-address width; DEPTH = 2**AW words
//  ROM_LAT   1           IROM read latency in cycles (1..4)
//  TICK_DIV  100_000_000 sys_clk_in cycles per run-mode tick (>= ROM_LAT+4)
//  CW        16          fetch counter width
// PORTS
//  sys_clk_in   in   1     single clock; all logic on rising edge
//  reset        in   1     synchronous, active-high reset
//  mode         in   2     00 HALT, 01 RUN, 10 STEP, 11 RUN_TO_BP
//  step_btn     in   1     raw step button, asynchronous; synchronised internally
//  bp_addr      in   XLEN  breakpoint byte address (compared on bits [AW+1:2])
//  pc_load      in   1     load request, sampled every cycle
//  pc_load_val  in   XLEN  byte address loaded on pc_load
//  rom_en       out  1     IROM enable
//  rom_addr     out  AW    IROM word address
//  rom_data     in   XLEN  IROM read data, valid ROM_LAT cycles after rom_en
//  pc           out  XLEN  byte address of the word in inst
//  inst         out  XLEN  last fetched instruction (held)
//  inst_valid   out  1     one-cycle pulse when inst/pc update
//  bp_hit       out  1     sticky breakpoint indicator
//  fetch_cnt    out  CW    completed fetches, wraps at 2**CW
// BEHAVIOUR
//  Reset (sync, highest priority)
//   - pc=0, inst=0, inst_valid=0, bp_hit=0, fetch_cnt=0, rom_en=0, rom_addr=0.
//   - Tick counter, step synchroniser and pending-load are cleared.
//   - FSM enters FETCH on the first cycle after reset is released (boot fetch of address 0).
//   - Reset mid-fetch aborts the fetch; no inst_valid is produced.
//  FSM: IDLE -> FETCH -> WAIT -> DONE -> IDLE
//   - FETCH (1 cycle): rom_en=1, rom_addr=pc[AW+1:2].
//   - WAIT: ROM_LAT-1 cycles; skipped when ROM_LAT=1.
//   - DONE (1 cycle): inst<=rom_data, inst_valid=1, fetch_cnt++.
//   - rom_en is 0 outside FETCH.
//   - Latency from advance event to inst_valid: ROM_LAT+1 cycles.
//  Advance event (IDLE only)
//   - pc <= {pc[XLEN-1:AW+2], (pc[AW+1:2]+1) mod DEPTH, 2'b00}; word index wraps DEPTH-1 -> 0.
//   - Same cycle: FSM -> FETCH.
//   - RUN, RUN_TO_BP: advance on a tick pulse. The tick counter runs 0..TICK_DIV-1 continuously in every mode.
//   - STEP: advance on a rising edge of step_btn after a 2-FF synchroniser.
//   - HALT: no advance.
//   - Ticks and step edges arriving outside IDLE are dropped, not queued.
//  pc_load
//   - In IDLE: pc <= {pc_load_val[XLEN-1:2],2'b00} and FSM -> FETCH. Takes priority over a same-cycle advance.
//   - While busy: value is captured into a single pending slot (last request wins) and applied on return to IDLE, before any advance.
//   - bp_hit is cleared on load.
//  Breakpoint (RUN_TO_BP only)
//   - In DONE, if pc[AW+1:2]==bp_addr[AW+1:2]: bp_hit<=1.
//   - While bp_hit=1, further advances are suppressed.
//   - bp_hit is cleared by reset, pc_load, or any change of mode.
//   - bp_hit is never set by the boot fetch.
//  Changes of mode take effect on the next cycle; they never abort an in-flight fetch.
//  pc bits above AW+1 are preserved; only the word index wraps.
// TESTING
//  1 reset 5 cyc, mode=HALT, ROM[i]=i*0x11 -> single inst_valid at cyc ROM_LAT+2 after release, pc=0, inst=0, then idle.
//  2 TICK_DIV=8, RUN -> inst_valid every 8 cyc; pc 0,4,..,0xFC, then wraps to 0 (AW=6); fetch_cnt=65 after the wrap fetch.
//  3 STEP; pulse step_btn 3 times (>=3 cyc high, 20 cyc apart) -> exactly 3 inst_valid; pc=0x0C; a bouncing pulse inside a fetch is dropped.
//  4 RUN_TO_BP, bp_addr=0x14 -> bp_hit=1 with pc=0x14; no further inst_valid for 100 ticks; mode->RUN clears bp_hit and advances resume.
//  5 pc_load=1, val=0x23 during WAIT -> current fetch completes, then fetch at pc=0x20 with no intervening advance.
//  6 ROM_LAT=3 variant: rom_en high 1 cyc; inst_valid 4 cyc after advance; reset asserted in WAIT -> no inst_valid, pc=0.

Source files
------------

// File: rtl/irom_fetch_stepper.sv
// Owns the PC and sequences synchronous-IROM fetches in free-run, single-step or run-to-breakpoint mode.
// Advance to inst_valid takes ROM_LAT+1 cycles; advance requests that arrive while a fetch is in flight are dropped.
module irom_fetch_stepper #(
    parameter int XLEN     = 32,
    parameter int AW       = 6,
    parameter int ROM_LAT  = 1,
    parameter int TICK_DIV = 100_000_000,
    parameter int CW       = 16
) (
    input  logic            sys_clk_in,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic            step_btn,
    input  logic [XLEN-1:0] bp_addr,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_load_val,
    output logic            rom_en,
    output logic [AW-1:0]   rom_addr,
    input  logic [XLEN-1:0] rom_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst,
    output logic            inst_valid,
    output logic            bp_hit,
    output logic [CW-1:0]   fetch_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] M_HALT = 2'd0;
    localparam logic [1:0] M_RUN  = 2'd1;
    localparam logic [1:0] M_STEP = 2'd2;
    localparam logic [1:0] M_RTB  = 2'd3;

    localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [1:0]     WAIT_LAST = 2'((ROM_LAT > 1) ? (ROM_LAT - 2) : 0);

    logic [1:0]      state;
    logic [1:0]      wait_cnt;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic            step_s1;
    logic            step_s2;
    logic            step_s3;
    logic            step_rise;
    logic [1:0]      mode_q;
    logic            boot_pend;
    logic            boot_fetch;
    logic            pend_vld;
    logic [XLEN-1:0] pend_val;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] pc_seq;
    logic [AW-1:0]   idx_inc;
    logic            advance;
    logic            mode_chg;
    logic            unused_bits;

    assign tick      = (tick_cnt == TICK_LAST);
    assign step_rise = step_s2 & ~step_s3;
    assign mode_chg  = (mode != mode_q);
    assign idx_inc   = pc[AW+1:2] + AW'(1);
    assign pc_seq    = {pc[XLEN-1:AW+2], idx_inc, 2'b00};
    assign load_pc   = pc_load ? {pc_load_val[XLEN-1:2], 2'b00} : pend_val;
    assign advance   = !bp_hit &&
                       ((((mode_q == M_RUN) || (mode_q == M_RTB)) && tick) ||
                        ((mode_q == M_STEP) && step_rise));

    assign rom_en   = (state == ST_FETCH);
    assign rom_addr = pc[AW+1:2];

    assign unused_bits = ^{bp_addr[XLEN-1:AW+2], bp_addr[1:0], pc_load_val[1:0]};

    always_ff @(posedge sys_clk_in) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            tick_cnt   <= '0;
            step_s1    <= 1'b0;
            step_s2    <= 1'b0;
            step_s3    <= 1'b0;
            mode_q     <= M_HALT;
            boot_pend  <= 1'b1;
            boot_fetch <= 1'b0;
            pend_vld   <= 1'b0;
            pend_val   <= '0;
            pc         <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            bp_hit     <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            inst_valid <= 1'b0;
            tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
            step_s1    <= step_btn;
            step_s2    <= step_s1;
            step_s3    <= step_s2;
            mode_q     <= mode;

            if (pc_load || mode_chg)
                bp_hit <= 1'b0;

            // A load requested mid-fetch is parked; the newest request overwrites any older one.
            if ((state != ST_IDLE) && pc_load) begin
                pend_vld <= 1'b1;
                pend_val <= {pc_load_val[XLEN-1:2], 2'b00};
            end

            case (state)
                ST_IDLE: begin
                    if (pc_load || pend_vld) begin
                        pc         <= load_pc;
                        pend_vld   <= 1'b0;
                        boot_pend  <= 1'b0;
                        boot_fetch <= 1'b0;
                        state      <= ST_FETCH;
                    end else if (boot_pend) begin
                        boot_pend  <= 1'b0;
                        boot_fetch <= 1'b1;
                        state      <= ST_FETCH;
                    end else if (advance) begin
                        pc         <= pc_seq;
                        boot_fetch <= 1'b0;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    wait_cnt <= '0;
                    state    <= (ROM_LAT > 1) ? ST_WAIT : ST_DONE;
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST)
                        state <= ST_DONE;
                    else
                        wait_cnt <= wait_cnt + 2'd1;
                end
                default: begin
                    inst       <= rom_data;
                    inst_valid <= 1'b1;
                    fetch_cnt  <= fetch_cnt + CW'(1);
                    if ((mode_q == M_RTB) && !boot_fetch && !pc_load && !mode_chg &&
                        (pc[AW+1:2] == bp_addr[AW+1:2]))
                        bp_hit <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irom_fetch_stepper.sv
// Directed bench: a ROM_LAT=1 and a ROM_LAT=3 instance share stimulus, each fed by its own IROM model.
module tb_irom_fetch_stepper;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        step_btn;
    logic [31:0] bp_addr;
    logic        pc_load;
    logic [31:0] pc_load_val;

    logic        rom_en, rom_en3;
    logic [5:0]  rom_addr, rom_addr3;
    logic [31:0] rom_data, rom_data3;
    logic [31:0] pc, pc3;
    logic [31:0] inst, inst3;
    logic        inst_valid, inst_valid3;
    logic        bp_hit, bp_hit3;
    logic [15:0] fetch_cnt, fetch_cnt3;

    logic [31:0] p1, p2, p3;

    int n_assert = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    int n        = 0;

    irom_fetch_stepper #(.XLEN(32), .AW(6), .ROM_LAT(1), .TICK_DIV(8), .CW(16)) dut (
        .sys_clk_in(clk), .reset(rst), .mode(mode), .step_btn(step_btn), .bp_addr(bp_addr),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .pc(pc), .inst(inst), .inst_valid(inst_valid), .bp_hit(bp_hit),
        .fetch_cnt(fetch_cnt)
    );

    irom_fetch_stepper #(.XLEN(32), .AW(6), .ROM_LAT(3), .TICK_DIV(8), .CW(16)) dut3 (
        .sys_clk_in(clk), .reset(rst), .mode(mode), .step_btn(step_btn), .bp_addr(bp_addr),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .rom_en(rom_en3), .rom_addr(rom_addr3),
        .rom_data(rom_data3), .pc(pc3), .inst(inst3), .inst_valid(inst_valid3), .bp_hit(bp_hit3),
        .fetch_cnt(fetch_cnt3)
    );

    function automatic logic [31:0] rom_word(input logic [5:0] a);
        return {26'b0, a} * 32'h11;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en)
            rom_data <= rom_word(rom_addr);
        if (rom_en3)
            p1 <= rom_word(rom_addr3);
        p2 <= p1;
        p3 <= p2;
    end
    assign rom_data3 = p3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(negedge clk);
            if (inst_valid)
                vcnt++;
        end
    endtask

    task automatic wait_valid(input int maxc, input string tag, output int cnt);
        logic got;
        got = 1'b0;
        cnt = 0;
        while (!got && cnt < maxc) begin
            @(negedge clk);
            cnt++;
            got = inst_valid;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_fetch(input logic use3, input string tag);
        logic got;
        int   c;
        got = 1'b0;
        c   = 0;
        while (!got && c < 12) begin
            @(negedge clk);
            c++;
            got = use3 ? rom_en3 : rom_en;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        mode        = 2'b00;
        step_btn    = 1'b0;
        bp_addr     = 32'h0;
        pc_load     = 1'b0;
        pc_load_val = 32'h0;

        // 1: reset values and single boot fetch in HALT
        repeat (5) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_bp", 32'(bp_hit), 32'd0);
        chk("rst_cnt", 32'(fetch_cnt), 32'd0);
        chk("rst_romen", 32'(rom_en), 32'd0);
        chk("rst_romaddr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("boot_romen", 32'(rom_en), 32'd1);
        chk("boot_romaddr", 32'(rom_addr), 32'd0);
        chk("boot3_romen", 32'(rom_en3), 32'd1);
        @(negedge clk);
        chk("boot3_romen_1cyc", 32'(rom_en3), 32'd0);
        chk("boot_valid_early", 32'(inst_valid), 32'd0);
        @(negedge clk);
        chk("boot_valid", 32'(inst_valid), 32'd1);
        chk("boot_pc", pc, 32'h0);
        chk("boot_inst", inst, 32'h0);
        chk("boot_cnt", 32'(fetch_cnt), 32'd1);
        @(negedge clk);
        chk("boot3_valid_early", 32'(inst_valid3), 32'd0);
        @(negedge clk);
        chk("boot3_valid", 32'(inst_valid3), 32'd1);
        vcnt = 0;
        cyc(20);
        chk("halt_idle", 32'(vcnt), 32'd0);

        // 2: free run, one fetch per tick, word index wraps
        mode = 2'b01;
        wait_valid(20, "run_first", n);
        chk("run_first_pc", pc, 32'h4);
        chk("run_first_inst", inst, 32'h11);
        for (int i = 2; i <= 64; i++) begin
            wait_valid(12, "run_valid", n);
            chk("run_gap", 32'(n), 32'd8);
            chk("run_pc", pc, 32'((i * 4) % 256));
            chk("run_inst", inst, 32'((i % 64) * 17));
        end
        chk("run_wrap_cnt", 32'(fetch_cnt), 32'd65);
        mode = 2'b00;
        cyc(10);

        // 3: single step with a bounce landing inside the fetch
        mode = 2'b10;
        cyc(3);
        vcnt = 0;
        step_btn = 1'b1; cyc(1);
        step_btn = 1'b0; cyc(1);
        step_btn = 1'b1; cyc(3);
        step_btn = 1'b0; cyc(20);
        for (int k = 0; k < 2; k++) begin
            step_btn = 1'b1; cyc(3);
            step_btn = 1'b0; cyc(20);
        end
        chk("step_count", 32'(vcnt), 32'd3);
        chk("step_pc", pc, 32'h0C);
        chk("step_inst", inst, 32'h33);
        chk("step_cnt", 32'(fetch_cnt), 32'd68);

        // 4: run to breakpoint, hold, then resume by mode change
        bp_addr = 32'h14;
        mode    = 2'b11;
        n = 0;
        while (!bp_hit && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_set", 32'(bp_hit), 32'd1);
        chk("bp_pc", pc, 32'h14);
        chk("bp_inst", inst, 32'h55);
        vcnt = 0;
        cyc(800);
        chk("bp_hold_count", 32'(vcnt), 32'd0);
        chk("bp_sticky", 32'(bp_hit), 32'd1);
        chk("bp_hold_pc", pc, 32'h14);
        mode = 2'b01;
        @(negedge clk);
        chk("bp_clear", 32'(bp_hit), 32'd0);
        wait_valid(20, "resume_valid", n);
        chk("resume_pc", pc, 32'h18);
        mode = 2'b00;
        cyc(10);

        // 5: load while busy is parked and applied before any advance
        mode = 2'b10;
        cyc(3);
        step_btn = 1'b1;
        wait_fetch(1'b0, "load_fetch_seen");
        pc_load     = 1'b1;
        pc_load_val = 32'h23;
        @(negedge clk);
        pc_load = 1'b0;
        wait_valid(10, "load_cur_valid", n);
        chk("load_cur_pc", pc, 32'h1C);
        chk("load_cur_inst", inst, 32'h77);
        step_btn = 1'b0;
        wait_valid(10, "load_new_valid", n);
        chk("load_new_gap", 32'(n), 32'd3);
        chk("load_new_pc", pc, 32'h20);
        chk("load_new_inst", inst, 32'h88);
        chk("load_new_cnt", 32'(fetch_cnt), 32'd73);
        cyc(10);

        // 6: ROM_LAT=3 timing, then reset during WAIT
        step_btn = 1'b1;
        wait_fetch(1'b1, "lat3_fetch_seen");
        @(negedge clk);
        chk("lat3_romen_1cyc", 32'(rom_en3), 32'd0);
        repeat (2) @(negedge clk);
        chk("lat3_valid_early", 32'(inst_valid3), 32'd0);
        @(negedge clk);
        chk("lat3_valid", 32'(inst_valid3), 32'd1);
        chk("lat3_pc", pc3, 32'h24);
        chk("lat3_inst", inst3, 32'h99);
        step_btn = 1'b0;
        cyc(10);
        step_btn = 1'b1;
        wait_fetch(1'b1, "abort_fetch_seen");
        @(negedge clk);
        rst      = 1'b1;
        step_btn = 1'b0;
        mode     = 2'b11;
        bp_addr  = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_valid", 32'(inst_valid3), 32'd0);
            chk("abort_pc", pc3, 32'h0);
        end
        chk("abort_cnt", 32'(fetch_cnt3), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reboot_valid", 32'(inst_valid), 32'd1);
        chk("reboot_bp", 32'(bp_hit), 32'd0);
        repeat (2) @(negedge clk);
        chk("reboot3_valid", 32'(inst_valid3), 32'd1);
        chk("reboot3_pc", pc3, 32'h0);
        chk("reboot3_bp", 32'(bp_hit3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
